// File: rtl/program_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to program memory.
// Optional trailing XOR checksum is compiled in with `define LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WriteEnable,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    localparam int unsigned INDEX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } loaderState_t;

    loaderState_t state, nextState;

    logic               hdrSecond;
    logic [7:0]         nLow;
    logic [1:0]         byteCount;
    logic [23:0]        assembly;
    logic [INDEX_W-1:0] wordIndex;
    logic [INDEX_W-1:0] lastIndex;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         checksum;
`endif

    logic        take;
    logic        enterHeader;
    logic [15:0] headerN;
    logic        headerIllegal;
    logic        finalByte;

    always_comb begin
        take          = ByteValid && ByteReady;
        enterHeader   = Start && ((state == IDLE) || (state == DONE) || (state == ERROR));
        headerN       = {ByteIn, nLow};
        headerIllegal = (headerN == 16'd0) || (32'(headerN) > MEMORY_DEPTH);
        finalByte     = (byteCount == 2'd3) && (wordIndex == lastIndex);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ByteReady = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        CpuHold   = 1'b1;
        case (state)
            IDLE: begin
                if (Start) nextState = HEADER;
            end
            HEADER: begin
                ByteReady = 1'b1;
                if (take && hdrSecond) nextState = headerIllegal ? ERROR : LOAD;
            end
            LOAD: begin
                ByteReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (take && finalByte) nextState = CHECK;
`else
                if (take && finalByte) nextState = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                ByteReady = 1'b1;
                if (take) nextState = (ByteIn == checksum) ? DONE : ERROR;
            end
`endif
            DONE: begin
                Done    = 1'b1;
                CpuHold = 1'b0;
                if (Start) nextState = HEADER;
            end
            ERROR: begin
                Error = 1'b1;
                if (Start) nextState = HEADER;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdrSecond    <= 1'b0;
            nLow         <= '0;
            byteCount    <= '0;
            assembly     <= '0;
            wordIndex    <= '0;
            lastIndex    <= '0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            WriteEnable <= 1'b0;
            if (enterHeader) begin
                hdrSecond <= 1'b0;
                byteCount <= '0;
                wordIndex <= '0;
`ifdef LOADER_CHECKSUM_EN
                checksum  <= '0;
`endif
            end
            if (take) begin
                case (state)
                    HEADER: begin
                        if (!hdrSecond) begin
                            nLow      <= ByteIn;
                            hdrSecond <= 1'b1;
                        end else begin
                            // Only meaningful when N is legal; then N-1 always fits the index width.
                            lastIndex <= INDEX_W'(headerN - 16'd1);
                        end
                    end
                    LOAD: begin
`ifdef LOADER_CHECKSUM_EN
                        checksum  <= checksum ^ ByteIn;
`endif
                        byteCount <= byteCount + 2'd1;
                        case (byteCount)
                            2'd0: assembly[7:0]   <= ByteIn;
                            2'd1: assembly[15:8]  <= ByteIn;
                            2'd2: assembly[23:16] <= ByteIn;
                            default: begin
                                WriteData    <= {ByteIn, assembly};
                                WriteAddress <= {{(30 - INDEX_W){1'b0}}, wordIndex, 2'b00};
                                WriteEnable  <= 1'b1;
                                wordIndex    <= wordIndex + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: header-legality vector table, spec streams, reset and random images.
module tb_program_loader;

    localparam int unsigned DEPTH = 32;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
        .WriteData(WriteData), .CpuHold(CpuHold), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  img[$];
    logic [31:0] expAddr[$];
    logic [31:0] expData[$];
    bit          expDone;
    logic [31:0] obsAddr[$];
    logic [31:0] obsData[$];
    bit          obsDone[$];
    bit          bothHigh = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1 && WriteEnable === 1'b1) begin
            obsAddr.push_back(WriteAddress);
            obsData.push_back(WriteData);
            obsDone.push_back(Done === 1'b1);
        end
        if (Done === 1'b1 && Error === 1'b1) bothHigh <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, ByteReady, 0);
        check({tag, "_we"}, WriteEnable, 0);
        check({tag, "_addr"}, WriteAddress, 0);
        check({tag, "_data"}, WriteData, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_error"}, Error, 0);
        check({tag, "_hold"}, CpuHold, 1);
    endtask

    // Reference: parse the image per the stream format and derive writes and final status.
    function automatic void buildExpect();
        int unsigned n;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        expAddr.delete();
        expData.delete();
        expDone = 1'b0;
        n = 32'({img[1], img[0]});
        if (n == 0 || n > DEPTH) return;
        for (int unsigned i = 0; i < n; i++) begin
            expAddr.push_back(32'(4 * i));
            expData.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
`ifdef LOADER_CHECKSUM_EN
            x ^= img[2+4*i] ^ img[2+4*i+1] ^ img[2+4*i+2] ^ img[2+4*i+3];
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        expDone = (img[2+4*n] == x);
`else
        expDone = 1'b1;
`endif
    endfunction

    function automatic void makeImage(input logic [7:0] lo, input logic [7:0] hi, input int unsigned words);
        img.delete();
        img.push_back(lo);
        img.push_back(hi);
        for (int unsigned i = 0; i < words * 4; i++) img.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        if (words > 0) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 2; i < img.size(); i++) x ^= img[i];
            img.push_back(x);
        end
`endif
    endfunction

    function automatic void specImage();
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
        img.push_back(8'h2A);
`endif
    endfunction

    task automatic sendByte(input logic [7:0] b);
        bit sent = 1'b0;
        int guard = 0;
        ByteIn = b;
        ByteValid = 1'b1;
        while (!sent && guard <= 50) begin
            @(negedge clk);
            if (ByteReady === 1'b1) begin
                @(posedge clk);
                #1;
                sent = 1'b1;
            end else begin
                guard++;
            end
        end
        if (!sent) check("accept_timeout", ByteReady, 1);
        ByteValid = 1'b0;
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // gapMode: 0 back-to-back, 1 valid every other cycle, 2 random idle gaps.
    task automatic runImage(input int gapMode, input int startAt);
        int last;
        obsAddr.delete();
        obsData.delete();
        obsDone.delete();
        buildExpect();
        pulseStart();
        check("ready_after_start", ByteReady, 1);
        for (int i = 0; i < img.size(); i++) begin
            if (i == startAt) pulseStart();
            if (gapMode == 1) begin
                @(posedge clk);
                #1;
            end else if (gapMode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            sendByte(img[i]);
        end
        check("ready_end", ByteReady, 0);
        check("done_end", Done, expDone);
        check("error_end", Error, !expDone);
        check("hold_end", CpuHold, !expDone);
        @(negedge clk);
        #1;
        check("write_count", obsAddr.size(), expAddr.size());
        last = expAddr.size() - 1;
        if (obsAddr.size() == expAddr.size()) begin
            for (int i = 0; i < expAddr.size(); i++) begin
                check("write_addr", obsAddr[i], expAddr[i]);
                check("write_data", obsData[i], expData[i]);
                check("done_at_write", obsDone[i], (i == last) && !CHK);
            end
        end
    endtask

    task automatic checkSpecWrites();
        check("spec_count", obsData.size(), 2);
        if (obsData.size() == 2) begin
            check("spec_a0", obsAddr[0], 32'h0000_0000);
            check("spec_d0", obsData[0], 32'h1234_5678);
            check("spec_a1", obsAddr[1], 32'h0000_0004);
            check("spec_d1", obsData[1], 32'hDEAD_BEEF);
        end
    endtask

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        int unsigned words;
        bit          expErr;
    } hdrVec_t;

    hdrVec_t vecs[7];

    initial begin
        vecs[0] = '{8'h00, 8'h00, 0, 1'b1};
        vecs[1] = '{8'h21, 8'h00, 0, 1'b1};
        vecs[2] = '{8'h01, 8'h00, 1, 1'b0};
        vecs[3] = '{8'h20, 8'h00, 32, 1'b0};
        vecs[4] = '{8'h20, 8'h01, 0, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 0, 1'b1};
        vecs[6] = '{8'h1F, 8'h00, 31, 1'b0};

        reset = 1'b0;
        Start = 1'b0;
        ByteValid = 1'b0;
        ByteIn = 8'h00;
        #3;
        checkResetOutputs("rst_init");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        specImage();
        runImage(0, -1);
        checkSpecWrites();

`ifdef LOADER_CHECKSUM_EN
        specImage();
        img[img.size() - 1] = 8'h2B;
        runImage(0, -1);
        checkSpecWrites();
        check("badsum_error", Error, 1);
`endif

        specImage();
        runImage(1, 4);
        checkSpecWrites();

        for (int v = 0; v < 7; v++) begin
            makeImage(vecs[v].lo, vecs[v].hi, vecs[v].words);
            runImage(0, -1);
            check("vec_error", Error, vecs[v].expErr);
        end

        // Reset part-way through the first payload word.
        obsAddr.delete();
        obsData.delete();
        obsDone.delete();
        pulseStart();
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h78);
        sendByte(8'h56);
        #2;
        reset = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_no_write", obsAddr.size(), 0);
        check("rst_hold_after", CpuHold, 1);
        specImage();
        runImage(0, -1);
        checkSpecWrites();

        for (int r = 0; r < 12; r++) begin
            int unsigned n;
            n = $urandom_range(1, DEPTH);
            makeImage(n[7:0], 8'h00, n);
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) img[img.size() - 1] = img[img.size() - 1] ^ 8'h01;
`endif
            runImage(2, (r % 3 == 0) ? 3 : -1);
        end

        check("done_error_exclusive", bothHigh, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the processor's program memory. It receives an 8-bit byte stream over a valid/ready handshake and assembles the bytes little-endian into 32-bit instructions. Each instruction is written to program memory at word-aligned byte addresses, matching how the PC addresses instruction memory. The block holds the processor in reset (`CpuHold`) until a complete, well-formed image has been written.

## Interface
- `MEMORY_DEPTH`, default 32: program memory capacity in 32-bit words; the maximum accepted image length.
- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  load request; sampled only in IDLE, DONE or ERROR.
- `ByteIn`  in  8  incoming stream byte.
- `ByteValid`  in  1  `ByteIn` holds a valid byte.
- `ByteReady`  out  1  loader accepts a byte this cycle. A byte is transferred when `ByteValid && ByteReady` at a rising edge.
- `WriteEnable`  out  1  one-cycle program memory write strobe.
- `WriteAddress`  out  32  byte address of the write, always a multiple of 4.
- `WriteData`  out  32  instruction word to write.
- `CpuHold`  out  1  high keeps the processor core in reset.
- `Done`  out  1  image loaded successfully.
- `Error`  out  1  image rejected.

## Operation
- Stream format:
  - Header: word count N as 2 bytes, little-endian.
  - Payload: N words of 4 bytes each, least significant byte first.
  - Checksum: 1 byte, present only when checksum checking is compiled in (see Configuration).
- States and transitions:
  - IDLE → HEADER on `Start`.
  - HEADER: two bytes are accepted. If N == 0 or N > `MEMORY_DEPTH`, go to ERROR; otherwise go to LOAD.
  - LOAD: bytes are accepted and a byte counter (0..3) steers each byte into the assembly register. When the 4th byte is accepted, the word is registered onto `WriteData`, `WriteAddress = 4*index`, `WriteEnable` pulses, and the word index increments. After word N-1, go to CHECK (checksum on) or DONE (checksum off).
  - CHECK: one byte is accepted and compared with the running XOR of all payload bytes; the header bytes are not included. Equal → DONE, unequal → ERROR.
  - DONE: `Done`=1, `CpuHold`=0. `Start` → HEADER.
  - ERROR: `Error`=1, `CpuHold`=1. `Start` → HEADER.
- `ByteReady` = 1 exactly in HEADER, LOAD and CHECK.
- Entering HEADER clears `Done`, `Error`, the byte counter, the word index and the checksum, and sets `CpuHold`=1.
- `Start` while in HEADER, LOAD or CHECK is ignored.
- `ByteValid` may drop for any number of cycles; the loader waits with its state unchanged.
- Width rules:
  - The word index counts 0..`MEMORY_DEPTH`-1.
  - `WriteAddress` is the index shifted left by 2 and zero-extended to 32 bits.
  - The 16-bit N is compared against `MEMORY_DEPTH` unsigned.
- Reset mid-load: all state and outputs return to their reset values and any partially assembled word is discarded. Program memory words already written are not restored.

## Timing
- Reset values:
  - State IDLE.
  - `ByteReady`=0, `WriteEnable`=0, `WriteAddress`=0, `WriteData`=0, `Done`=0, `Error`=0.
  - `CpuHold`=1.
- `Start` sampled high at edge t → `ByteReady`=1 from edge t onward.
- The 4th byte of a word accepted at edge k → `WriteEnable`=1 for the single cycle following edge k, with `WriteAddress`/`WriteData` valid in that same cycle. All three outputs are registered.
- `ByteReady` stays high during a write cycle, so one byte per cycle is sustainable.
- Second header byte accepted at edge k with an illegal N → `Error`=1 and `ByteReady`=0 after edge k.
- Checksum off: the final word's `WriteEnable` cycle coincides with `Done`=1 and `CpuHold`=0.
- Checksum on: checksum byte accepted at edge k → `Done` or `Error` after edge k. No `WriteEnable` is issued in that cycle.
- `Done` and `Error` are never high simultaneously.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CHECK state, the XOR accumulator and the trailing checksum byte are all present.
  - A checksum mismatch → ERROR.
- `LOADER_CHECKSUM_EN` undefined:
  - No CHECK state and no checksum byte; LOAD goes directly to DONE.
  - `Error` is raised only for an illegal N.

## Test plan
- Reset asserted mid-operation → all outputs take their reset values immediately: `CpuHold`=1, all other outputs 0.
- Load with checksum on:
  - Stimulus: `Start`, then bytes 02 00, 78 56 34 12, EF BE AD DE, 2A.
  - Response: writes (0x0, 0x12345678) and (0x4, 0xDEADBEEF), then `Done`=1, `CpuHold`=0.
- Same stream with checksum byte 2B → both words are written, then `Error`=1, `Done`=0, `CpuHold`=1.
- Illegal length: header 21 00 (N=33) with `MEMORY_DEPTH`=32 → `Error`=1 after the 2nd header byte, no `WriteEnable`. Header 00 00 (N=0) → same response.
- Stream from the second scenario with `ByteValid` toggling every other cycle and a `Start` pulse during LOAD → identical writes and `Done`; the `Start` pulse has no effect.
- `reset` pulsed low after 2 payload bytes → no write is issued and `CpuHold`=1. A new `Start` followed by the full stream from the second scenario → correct writes and `Done`=1.
